// File: rtl/tmds_encoder_mc.sv
// tmds_encoder_mc: multi-channel TMDS 8b/10b encoder, one instance per link.
// Each of NUM_CH lanes goes through a 2-stage pipeline: stage 1 forms the
// transition-minimised q_m word, and stage 2 applies DC balancing with a
// per-channel running disparity.
// With HDMI_MODE=1, the inputs first pass through a LEAD-deep lookahead line.
// This lets the encoder insert the video preamble and leading guard band ahead
// of each active run.
// Optional build macro TMDS_DISPARITY_MON_EN adds the o_disparity and
// o_bal_err monitor ports.
// Flow control: none. A new pixel or control word is accepted on every
// i_clk edge, and o_encoded/o_active carry a fixed-latency copy of it.
module tmds_encoder_mc #(
    parameter int NUM_CH    = 3,
    parameter int HDMI_MODE = 0,
    parameter int LEAD      = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_CH*8-1:0]    i_data,
    input  logic [NUM_CH*2-1:0]    i_control_data,
    input  logic                   i_blanking,
`ifdef TMDS_DISPARITY_MON_EN
    output logic [NUM_CH*5-1:0]    o_disparity,
    output logic                   o_bal_err,
`endif
    output logic [NUM_CH*10-1:0]   o_encoded,
    output logic                   o_active
);

    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] CTRL_01  = 10'b0010101011;
    localparam logic [9:0] CTRL_10  = 10'b0101010100;
    localparam logic [9:0] CTRL_11  = 10'b1010101011;
    localparam logic [9:0] GUARD_02 = 10'b1011001100;
    localparam logic [9:0] GUARD_1  = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Transition minimisation; q[8] = 1 marks the XOR variant.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] guard_code(input int ch);
        return (ch == 1) ? GUARD_1 : GUARD_02;
    endfunction

    // DC balancing. The result is {next_cnt[4:0], symbol[9:0]}.
    // bal = N1 - N0 over q_m[7:0].
    function automatic logic [14:0] stage2_encode(input logic [8:0] qm,
                                                  input logic signed [4:0] cnt);
        logic [3:0]        n1;
        logic signed [5:0] bal6;
        logic signed [4:0] bal;
        logic signed [4:0] nc;
        logic [9:0]        sym;
        n1   = ones8(qm[7:0]);
        bal6 = $signed({1'b0, n1, 1'b0}) - 6'sd8;
        bal  = bal6[4:0];
        if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nc  = qm[8] ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                     ((cnt < 5'sd0) && (bal < 5'sd0))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nc  = cnt + (qm[8] ? 5'sd2 : 5'sd0) - bal;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nc  = cnt - (qm[8] ? 5'sd0 : 5'sd2) + bal;
        end
        return {nc, sym};
    endfunction

    // Front end: the sample presented to stage 1, plus the guard-band flag.
    logic [NUM_CH*8-1:0] fe_data;
    logic [NUM_CH*2-1:0] fe_ctrl;
    logic                fe_blank;
    logic                fe_guard;

    if (HDMI_MODE != 0 && LEAD >= 10) begin : g_hdmi
        logic [NUM_CH*8-1:0] dl_data_q [LEAD];
        logic [NUM_CH*2-1:0] dl_ctrl_q [LEAD];
        logic [LEAD-1:0]     dl_blank_q;
        logic [LEAD:0]       blank_tap;
        logic                pre_hit;

        // Lookahead delay line; reset fills it with blanking / ctrl 00.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int j = 0; j < LEAD; j++) begin
                    dl_data_q[j] <= '0;
                    dl_ctrl_q[j] <= '0;
                end
                dl_blank_q <= '1;
            end else begin
                dl_data_q[0] <= i_data;
                dl_ctrl_q[0] <= i_control_data;
                for (int j = 1; j < LEAD; j++) begin
                    dl_data_q[j] <= dl_data_q[j-1];
                    dl_ctrl_q[j] <= dl_ctrl_q[j-1];
                end
                dl_blank_q <= {dl_blank_q[LEAD-2:0], i_blanking};
            end
        end

        // Bit LEAD is the delayed (current) sample. Bit LEAD-k is k cycles in its future.
        assign blank_tap = {dl_blank_q, i_blanking};

        // Guard when de rises within 2 cycles, preamble when it rises within 3..10.
        // The guard band takes priority over the preamble.
        always_comb begin
            pre_hit  = 1'b0;
            for (int k = 3; k <= 10; k++)
                if (!blank_tap[LEAD-k]) pre_hit = 1'b1;
            fe_blank = blank_tap[LEAD];
            fe_data  = dl_data_q[LEAD-1];
            fe_ctrl  = dl_ctrl_q[LEAD-1];
            fe_guard = fe_blank && (!blank_tap[LEAD-1] || !blank_tap[LEAD-2]);
            if (fe_blank && !fe_guard && pre_hit) begin
                for (int k = 1; k < NUM_CH && k < 3; k++)
                    fe_ctrl[2*k +: 2] = (k == 1) ? 2'b01 : 2'b00;
            end
        end
    end else begin : g_dvi
        // Plain DVI: inputs feed stage 1 directly.
        always_comb begin
            fe_data  = i_data;
            fe_ctrl  = i_control_data;
            fe_blank = i_blanking;
            fe_guard = 1'b0;
        end
    end

    // Stage 1 registers.
    logic [NUM_CH*9-1:0] s1_qm_d;
    logic [NUM_CH*9-1:0] s1_qm_q;
    logic [NUM_CH*2-1:0] s1_ctrl_q;
    logic                s1_blank_q;
    logic                s1_guard_q;

    // Stage 1 combinational: q_m for every lane.
    always_comb begin
        s1_qm_d = '0;
        for (int k = 0; k < NUM_CH; k++)
            s1_qm_d[9*k +: 9] = qm_encode(fe_data[8*k +: 8]);
    end

    // Stage 1 register; reset presents a blanking ctrl-00 slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_qm_q    <= '0;
            s1_ctrl_q  <= '0;
            s1_blank_q <= 1'b1;
            s1_guard_q <= 1'b0;
        end else begin
            s1_qm_q    <= s1_qm_d;
            s1_ctrl_q  <= fe_ctrl;
            s1_blank_q <= fe_blank;
            s1_guard_q <= fe_guard;
        end
    end

    // Stage 2 registers.
    logic [NUM_CH*10-1:0] enc_d;
    logic [NUM_CH*10-1:0] enc_q;
    logic [NUM_CH*5-1:0]  cnt_d;
    logic [NUM_CH*5-1:0]  cnt_q;
    logic                 active_q;

    // Stage 2 combinational: the control/guard symbol, or the DC-balanced data symbol.
    always_comb begin
        enc_d = '0;
        cnt_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (s1_blank_q) begin
                enc_d[10*k +: 10] = (s1_guard_q && k < 3) ? guard_code(k)
                                                          : ctrl_code(s1_ctrl_q[2*k +: 2]);
                cnt_d[5*k +: 5]   = '0;
            end else begin
                {cnt_d[5*k +: 5], enc_d[10*k +: 10]} =
                    stage2_encode(s1_qm_q[9*k +: 9], $signed(cnt_q[5*k +: 5]));
            end
        end
    end

    // Stage 2 register: output symbols, disparity counters and the active flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            enc_q    <= {NUM_CH{CTRL_00}};
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            enc_q    <= enc_d;
            cnt_q    <= cnt_d;
            active_q <= ~s1_blank_q;
        end
    end

    assign o_encoded = enc_q;
    assign o_active  = active_q;

`ifdef TMDS_DISPARITY_MON_EN
    logic bal_hit;
    logic bal_err_q;

    // Flag any lane whose next disparity leaves the legal -8..+8 window.
    always_comb begin
        bal_hit = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (($signed(cnt_d[5*k +: 5]) > 5'sd8) || ($signed(cnt_d[5*k +: 5]) < -5'sd8))
                bal_hit = 1'b1;
    end

    // Sticky balance-error flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)        bal_err_q <= 1'b0;
        else if (bal_hit) bal_err_q <= 1'b1;
    end

    assign o_disparity = cnt_q;
    assign o_bal_err   = bal_err_q;
`endif

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// tb_tmds_encoder_mc: runs a DVI instance and an HDMI_MODE instance side by
// side, driven from the same stimulus, with one expected-value queue per
// instance.
module tb_tmds_encoder_mc;

    localparam int NCH = 3;
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] G02 = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCH*8-1:0] data = '0;
    logic [NCH*2-1:0] ctrl = '0;
    logic blank = 1'b1;
    always #5 clk = ~clk;

    logic [NCH*10-1:0] dvi_enc, hdmi_enc;
    logic dvi_act, hdmi_act;
`ifdef TMDS_DISPARITY_MON_EN
    logic [NCH*5-1:0] dvi_disp, hdmi_disp;
    logic dvi_bal, hdmi_bal;
`endif

    tmds_encoder_mc #(.NUM_CH(NCH), .HDMI_MODE(0), .LEAD(10)) u_dvi (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_control_data(ctrl), .i_blanking(blank),
`ifdef TMDS_DISPARITY_MON_EN
        .o_disparity(dvi_disp), .o_bal_err(dvi_bal),
`endif
        .o_encoded(dvi_enc), .o_active(dvi_act));

    tmds_encoder_mc #(.NUM_CH(NCH), .HDMI_MODE(1), .LEAD(10)) u_hdmi (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_control_data(ctrl), .i_blanking(blank),
`ifdef TMDS_DISPARITY_MON_EN
        .o_disparity(hdmi_disp), .o_bal_err(hdmi_bal),
`endif
        .o_encoded(hdmi_enc), .o_active(hdmi_act));

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [NCH*10-1:0] sym;
        logic              act;
        logic [NCH*8-1:0]  src;
        logic [NCH*5-1:0]  cnt;
    } exp_t;

    exp_t dvi_q[$];
    exp_t hdmi_q[$];
    int checks = 0;
    int failures = 0;
    int dvi_cnt[NCH];
    int hdmi_cnt[NCH];
    logic hb[11];
    logic [NCH*8-1:0] hd[11];
    logic [NCH*2-1:0] hc[11];
    int pre_seen, grd_seen;

    // ---------------- reference model ----------------
    function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    task automatic ref_active(input logic [7:0] d, input int cin,
                              output logic [9:0] sym, output int cout);
        logic [8:0] qm;
        int n1d, n1, n0;
        bit xn;
        n1d = $countones(d);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (cin == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            cout = qm[8] ? cin + n1 - n0 : cin + n0 - n1;
        end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cout = cin - (qm[8] ? 0 : 2) + n1 - n0;
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        dvi_q.delete();
        hdmi_q.delete();
        for (int k = 0; k < NCH; k++) begin
            dvi_cnt[k] = 0;
            hdmi_cnt[k] = 0;
        end
        for (int i = 0; i < 11; i++) begin
            hb[i] = 1'b1;
            hd[i] = '0;
            hc[i] = '0;
        end
    endtask

    // ---------------- driver ----------------
    // Called on a negedge: compare matured entries, drive, push expectations, advance.
    task automatic step(input logic b, input logic [NCH*8-1:0] d, input logic [NCH*2-1:0] c,
                        input bit ovr, input logic [9:0] ovr_sym);
        exp_t e, h;
        logic [9:0] s;
        logic [1:0] cc;
        int nc;
        bit guard, pre;
        if (dvi_q.size() == 2) begin
            e = dvi_q.pop_front();
            check("dvi_sym", 32'(dvi_enc), 32'(e.sym));
            check("dvi_act", 32'(dvi_act), 32'(e.act));
            if (e.act)
                for (int k = 0; k < NCH; k++)
                    check("dvi_decode", 32'(ref_decode(dvi_enc[10*k +: 10])), 32'(e.src[8*k +: 8]));
`ifdef TMDS_DISPARITY_MON_EN
            check("dvi_disp", 32'(dvi_disp), 32'(e.cnt));
            check("dvi_bal", 32'(dvi_bal), 32'd0);
`endif
        end
        if (hdmi_q.size() == 2) begin
            h = hdmi_q.pop_front();
            check("hdmi_sym", 32'(hdmi_enc), 32'(h.sym));
            check("hdmi_act", 32'(hdmi_act), 32'(h.act));
`ifdef TMDS_DISPARITY_MON_EN
            check("hdmi_disp", 32'(hdmi_disp), 32'(h.cnt));
            check("hdmi_bal", 32'(hdmi_bal), 32'd0);
`endif
        end
        if (!hdmi_act) begin
            if (hdmi_enc[9:0] == G02) grd_seen++;
            else if (hdmi_enc[19:10] == C01 && hdmi_enc[29:20] == C00) pre_seen++;
        end

        blank = b;
        data = d;
        ctrl = c;

        // DVI expectation for this input
        e.act = !b;
        e.src = d;
        for (int k = 0; k < NCH; k++) begin
            if (b) begin
                s = ref_ctrl(c[2*k +: 2]);
                dvi_cnt[k] = 0;
            end else begin
                ref_active(d[8*k +: 8], dvi_cnt[k], s, nc);
                dvi_cnt[k] = nc;
            end
            e.sym[10*k +: 10] = s;
            e.cnt[5*k +: 5] = dvi_cnt[k][4:0];
        end
        if (ovr) e.sym[9:0] = ovr_sym;
        dvi_q.push_back(e);

        // HDMI expectation for the input 10 cycles back, whose whole lookahead is now known
        for (int i = 0; i < 10; i++) begin
            hb[i] = hb[i+1];
            hd[i] = hd[i+1];
            hc[i] = hc[i+1];
        end
        hb[10] = b;
        hd[10] = d;
        hc[10] = c;
        h.act = !hb[0];
        h.src = hd[0];
        guard = hb[0] && (!hb[1] || !hb[2]);
        pre = 1'b0;
        for (int i = 3; i <= 10; i++) if (!hb[i]) pre = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (!hb[0]) begin
                ref_active(hd[0][8*k +: 8], hdmi_cnt[k], s, nc);
                hdmi_cnt[k] = nc;
            end else begin
                hdmi_cnt[k] = 0;
                if (guard && k < 3) begin
                    s = (k == 1) ? G1 : G02;
                end else begin
                    cc = hc[0][2*k +: 2];
                    if (pre && !guard && k == 1) cc = 2'b01;
                    if (pre && !guard && k == 2) cc = 2'b00;
                    s = ref_ctrl(cc);
                end
            end
            h.sym[10*k +: 10] = s;
            h.cnt[5*k +: 5] = hdmi_cnt[k][4:0];
        end
        hdmi_q.push_back(h);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blank = 1'b1;
        data = '0;
        ctrl = '0;
        @(negedge clk);
        check("rst_dvi_sym", 32'(dvi_enc), 32'({NCH{C00}}));
        check("rst_dvi_act", 32'(dvi_act), 32'd0);
        check("rst_hdmi_sym", 32'(hdmi_enc), 32'({NCH{C00}}));
        check("rst_hdmi_act", 32'(hdmi_act), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [NCH*8-1:0] rnd_data();
        logic [NCH*8-1:0] v;
        for (int k = 0; k < NCH; k++) v[8*k +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // ---------------- vector tables ----------------
    typedef struct {
        logic       blank;
        logic [1:0] ctrl0;
        logic [7:0] data0;
        logic [9:0] exp0;
    } vec_t;

    typedef struct {
        int blank_len;
        int exp_pre;
        int exp_grd;
    } gap_t;

    vec_t vecs[14];
    gap_t gaps[4];

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 8'h00, 10'h354};
        vecs[1]  = '{1'b1, 2'b01, 8'h00, 10'h0AB};
        vecs[2]  = '{1'b1, 2'b10, 8'h00, 10'h154};
        vecs[3]  = '{1'b1, 2'b11, 8'h00, 10'h2AB};
        vecs[4]  = '{1'b0, 2'b00, 8'h00, 10'h100};
        vecs[5]  = '{1'b0, 2'b00, 8'h00, 10'h3FF};
        vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'h354};
        vecs[7]  = '{1'b0, 2'b00, 8'h00, 10'h100};
        vecs[8]  = '{1'b0, 2'b00, 8'hFF, 10'h0FF};
        vecs[9]  = '{1'b0, 2'b00, 8'h55, 10'h133};
        vecs[10] = '{1'b0, 2'b00, 8'h10, 10'h1F0};
        vecs[11] = '{1'b0, 2'b00, 8'h01, 10'h1FF};
        vecs[12] = '{1'b0, 2'b00, 8'h01, 10'h300};
        vecs[13] = '{1'b0, 2'b00, 8'hFF, 10'h200};
        gaps[0] = '{20, 8, 2};
        gaps[1] = '{10, 8, 2};
        gaps[2] = '{4, 2, 2};
        gaps[3] = '{1, 0, 1};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Hand-derived ch0 sequence starting from reset disparity 0
        for (int i = 0; i < 14; i++)
            step(vecs[i].blank, {16'h0000, vecs[i].data0}, {4'b0000, vecs[i].ctrl0}, 1'b1, vecs[i].exp0);

        // Alternating 0xFF/0x00, then walking one, on ch0; random on other lanes
        for (int i = 0; i < 30; i++) begin
            logic [NCH*8-1:0] v;
            v = rnd_data();
            v[7:0] = (i % 2 == 0) ? 8'hFF : 8'h00;
            step(1'b0, v, '0, 1'b0, '0);
        end
        for (int i = 0; i < 30; i++) begin
            logic [NCH*8-1:0] v;
            logic [7:0] w;
            v = rnd_data();
            w = 8'h01;
            v[7:0] = w << (i % 8);
            step(1'b0, v, '0, 1'b0, '0);
        end

        // Preamble / guard band placement for blanking runs of various lengths
        for (int g = 0; g < 4; g++) begin
            repeat (14) step(1'b0, rnd_data(), '0, 1'b0, '0);
            pre_seen = 0;
            grd_seen = 0;
            repeat (gaps[g].blank_len) step(1'b1, '0, '0, 1'b0, '0);
            repeat (14) step(1'b0, rnd_data(), '0, 1'b0, '0);
            check("gap_preamble", 32'(pre_seen), 32'(gaps[g].exp_pre));
            check("gap_guard", 32'(grd_seen), 32'(gaps[g].exp_grd));
        end

        // Random blanking runs with random control codes
        for (int r = 0; r < 24; r++) begin
            int len;
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                if (r % 2 == 0) step(1'b0, rnd_data(), 6'($urandom_range(0, 63)), 1'b0, '0);
                else            step(1'b1, rnd_data(), 6'($urandom_range(0, 63)), 1'b0, '0);
            end
        end

        // Reset in the middle of active video, then recovery
        repeat (6) step(1'b0, rnd_data(), '0, 1'b0, '0);
        do_reset();
        repeat (5) step(1'b1, '0, 6'b000100, 1'b0, '0);
        repeat (20) step(1'b0, rnd_data(), '0, 1'b0, '0);
        repeat (14) step(1'b1, '0, '0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
